// File: rtl/strike_source_pkg.sv
// rtl/strike_source_pkg.sv - shared 27 MHz-derived timing constants
package strike_source_pkg;

  // 100 ms at 27 MHz
  localparam int HOLDOFF_CYCLES_100MS = 2700000;

endpackage

// File: rtl/strike_source_if.sv
// rtl/strike_source_if.sv - mistake collection / strike issue bundle
interface strike_source_if #(
  parameter int NUM_MODULES = 4
);
  logic [NUM_MODULES-1:0] mistake;
  logic [NUM_MODULES-1:0] enable;
  logic                   exploded;
  logic                   strike;
  logic                   buzzer;
  logic [NUM_MODULES-1:0] pending;

  modport master (
    output mistake, enable, exploded,
    input  strike, buzzer, pending
  );

  modport slave (
    input  mistake, enable, exploded,
    output strike, buzzer, pending
  );
endinterface

// File: rtl/strike_source_rise_detect.sv
// rtl/strike_source_rise_detect.sv - registered rising-edge detector
// prev always loads the live level, so a level already high at reset release never looks like an edge.
module strike_source_rise_detect #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clock) begin
    prev <= level;
  end

  assign rise = level & ~prev & ~{WIDTH{reset}};
endmodule

// File: rtl/strike_source.sv
// rtl/strike_source.sv - turns per-module mistake edges into spaced single strike pulses
module strike_source
  import strike_source_pkg::*;
#(
  parameter int NUM_MODULES = 4,
  parameter int HOLDOFF     = HOLDOFF_CYCLES_100MS,
  parameter int CNT_W       = 22
) (
  input  logic           clock,
  input  logic           reset,
  strike_source_if.slave bus
);
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_HOLDOFF = 1'b1;

  logic [0:0]             state;
  logic [CNT_W-1:0]       count;
  logic                   strike;
  logic                   buzzer;
  logic [NUM_MODULES-1:0] pending;
  logic [NUM_MODULES-1:0] sample;
  logic [NUM_MODULES-1:0] rise;
  logic [NUM_MODULES-1:0] lowest;
  logic [NUM_MODULES-1:0] kept;

  assign sample = bus.mistake & bus.enable;

  strike_source_rise_detect #(.WIDTH(NUM_MODULES)) u_rise (
    .clock (clock),
    .reset (reset),
    .level (sample),
    .rise  (rise)
  );

  // one-hot of the lowest set pending bit; that module is issued first
  assign lowest = pending & (~pending + NUM_MODULES'(1));
  // a rise on the same edge as the issue re-sets the bit, so the OR comes last
  assign kept   = (state == ST_IDLE) ? (pending & ~lowest) : pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      strike  <= 1'b0;
      buzzer  <= 1'b0;
      pending <= '0;
    end else if (bus.exploded) begin
      state   <= ST_IDLE;
      count   <= '0;
      strike  <= 1'b0;
      buzzer  <= 1'b0;
      pending <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending != '0) begin
            strike <= 1'b1;
            buzzer <= 1'b1;
            count  <= CNT_W'(HOLDOFF - 1);
            state  <= ST_HOLDOFF;
          end else begin
            strike <= 1'b0;
            buzzer <= 1'b0;
          end
        end
        default: begin
          strike <= 1'b0;
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            buzzer <= 1'b0;
            state  <= ST_IDLE;
          end
        end
      endcase
      pending <= kept | rise;
    end
  end

  assign bus.strike  = strike;
  assign bus.buzzer  = buzzer;
  assign bus.pending = pending;
endmodule

// File: tb/tb_strike_source.sv
// tb/tb_strike_source.sv - directed scoreboard bench for strike_source
module tb_strike_source;
  localparam int N  = 4;
  localparam int HO = 4;

  logic clock;
  logic reset;
  int   cyc;
  int   tests;
  int   fails;
  int   exp_q[$];
  int   c;

  strike_source_if #(.NUM_MODULES(N)) bus ();

  strike_source #(.NUM_MODULES(N), .HOLDOFF(HO), .CNT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // scoreboard: each observed strike must match the next expected edge number
  always @(negedge clock) begin
    if (bus.strike === 1'b1) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_strike observed=cycle %0d expected=none", cyc);
      end
      if (exp_q.size() != 0) begin
        int e;
        e = exp_q.pop_front();
        tests++;
        assert (cyc === e) else begin
          fails++;
          $error("FAIL strike_cycle observed=%0d expected=%0d", cyc, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    cyc = 0; tests = 0; fails = 0;
    reset = 1'b1;
    bus.mistake = '0; bus.enable = 4'b1111; bus.exploded = 1'b0;
    tick(2);
    check("reset_strike", {7'd0, bus.strike}, 8'd0);
    check("reset_buzzer", {7'd0, bus.buzzer}, 8'd0);
    check("reset_pending", {4'd0, bus.pending}, 8'd0);
    tick(1);
    reset = 1'b0;
    tick(3);

    // single mistake
    c = cyc; bus.mistake = 4'b0001; exp_q.push_back(c + 2);
    tick(1); bus.mistake = 4'b0000;
    check("single_pending_set", {4'd0, bus.pending}, 8'h01);
    tick(1);
    check("single_strike", {7'd0, bus.strike}, 8'd1);
    check("single_buzzer_on", {7'd0, bus.buzzer}, 8'd1);
    check("single_pending_clr", {4'd0, bus.pending}, 8'h00);
    tick(1);
    check("single_strike_one_cycle", {7'd0, bus.strike}, 8'd0);
    tick(2);
    check("single_buzzer_last", {7'd0, bus.buzzer}, 8'd1);
    tick(1);
    check("single_buzzer_off", {7'd0, bus.buzzer}, 8'd0);
    tick(4);

    // simultaneous mistakes held high
    c = cyc; bus.mistake = 4'b0101;
    exp_q.push_back(c + 2); exp_q.push_back(c + 2 + HO + 1);
    tick(1);
    check("simul_pending", {4'd0, bus.pending}, 8'h05);
    tick(1);
    check("simul_first_is_mod0", {4'd0, bus.pending}, 8'h04);
    tick(HO + 1);
    check("simul_second_strike", {7'd0, bus.strike}, 8'd1);
    check("simul_pending_empty", {4'd0, bus.pending}, 8'h00);
    tick(10);
    bus.mistake = 4'b0000;
    tick(3);

    // masked module produces nothing
    bus.enable = 4'b1110; bus.mistake = 4'b0001;
    tick(1); bus.mistake = 4'b0000;
    tick(1);
    check("masked_pending", {4'd0, bus.pending}, 8'h00);
    bus.enable = 4'b1111;
    tick(3);

    // saturation: two edges on module 1 during a holdoff give one strike
    c = cyc; bus.mistake = 4'b1000; exp_q.push_back(c + 2);
    tick(1); bus.mistake = 4'b0000;
    tick(1); bus.mistake = 4'b0010;
    tick(1); bus.mistake = 4'b0000;
    tick(1); bus.mistake = 4'b0010;
    tick(1); bus.mistake = 4'b0000;
    exp_q.push_back(c + 2 + HO + 1);
    tick(1);
    check("saturate_pending", {4'd0, bus.pending}, 8'h02);
    tick(10);

    // flag held through reset
    reset = 1'b1; bus.mistake = 4'b0010;
    tick(3);
    check("reset_hold_buzzer", {7'd0, bus.buzzer}, 8'd0);
    reset = 1'b0;
    tick(3);
    check("held_no_pending", {4'd0, bus.pending}, 8'h00);
    bus.mistake = 4'b0000;
    tick(1);
    c = cyc; bus.mistake = 4'b0010; exp_q.push_back(c + 2);
    tick(1); bus.mistake = 4'b0000;
    tick(HO + 4);

    // reset in the middle of a holdoff
    c = cyc; bus.mistake = 4'b0001; exp_q.push_back(c + 2);
    tick(1); bus.mistake = 4'b0000;
    tick(1); bus.mistake = 4'b1000;
    tick(1);
    check("midhold_buzzer", {7'd0, bus.buzzer}, 8'd1);
    check("midhold_pending", {4'd0, bus.pending}, 8'h08);
    reset = 1'b1;
    tick(1);
    check("midhold_rst_strike", {7'd0, bus.strike}, 8'd0);
    check("midhold_rst_buzzer", {7'd0, bus.buzzer}, 8'd0);
    check("midhold_rst_pending", {4'd0, bus.pending}, 8'h00);
    reset = 1'b0;
    tick(10);
    bus.mistake = 4'b0000;
    tick(2);

    // explosion freeze
    bus.mistake = 4'b0011;
    tick(1);
    check("explode_pre_pending", {4'd0, bus.pending}, 8'h03);
    bus.exploded = 1'b1;
    tick(1);
    check("explode_strike", {7'd0, bus.strike}, 8'd0);
    check("explode_pending", {4'd0, bus.pending}, 8'h00);
    bus.mistake = 4'b0000;
    tick(1); bus.mistake = 4'b0100;
    tick(1);
    check("explode_new_edge", {4'd0, bus.pending}, 8'h00);
    tick(2);
    bus.exploded = 1'b0;
    tick(10);
    check("explode_release_buzzer", {7'd0, bus.buzzer}, 8'd0);
    bus.mistake = 4'b0000;
    tick(2);

    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL missing_strikes observed=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
